// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_arbiter
//  Purpose  : Shares one single-port unified SRAM between the MIPS core's
//             instruction-fetch port (IF) and its load/store port (DM).
//             Accesses are serialised as IDLE -> ISSUE -> WAIT -> DONE.
//             The memory has a fixed read latency. Completion is signalled
//             with a one-cycle ack. DM wins ties, but a starvation counter
//             forces an IF grant after STARVE_MAX consecutive DM wins.
//  Ports    : clk, rst             clock, synchronous active-high reset
//             if_req/if_addr       fetch request and address
//             if_rdata/if_ack      fetch data and completion pulse
//             dm_req/dm_we/dm_be   load/store request, write enable, byte enables
//             dm_addr/dm_wdata     load/store address and store data
//             dm_rdata/dm_ack      load data and completion pulse
//             mem_en/mem_we/mem_be memory strobe, write enable, byte enables
//             mem_addr/mem_wdata   memory address and write data
//             mem_rdata            memory read data (MEM_LAT cycles after mem_en)
//             busy                 high whenever the arbiter is not idle
//  Revision : 1.0  initial release
// ============================================================================
module mips_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,   // legal 1..4
    parameter int STARVE_MAX = 4    // legal 1..15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ack,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int         BE_W       = DATA_W / 8;
    localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic       OWNER_IF   = 1'b1;
    localparam logic       OWNER_DM   = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we_q, we_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [1:0]         lat_cnt_q, lat_cnt_d;
    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]  dm_rdata_q, dm_rdata_d;
    logic               w_grant_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWNER_DM;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            lat_cnt_q    <= 2'd0;
            starve_cnt_q <= 4'd0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // IF wins only when DM is absent or IF has waited out STARVE_MAX DM grants
    assign w_grant_if = if_req && (!dm_req || (starve_cnt_q == STARVE_LIM));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    state_d = S_ISSUE;
                    if (w_grant_if) begin
                        // Fetches are always full-word reads
                        owner_d      = OWNER_IF;
                        addr_d       = if_addr;
                        we_d         = 1'b0;
                        be_d         = '1;
                        wdata_d      = '0;
                        starve_cnt_d = 4'd0;
                    end else begin
                        owner_d = OWNER_DM;
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        be_d    = dm_be;
                        wdata_d = dm_wdata;
                        if (!if_req) begin
                            starve_cnt_d = 4'd0;
                        end else if (starve_cnt_q != STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end
                end
            end
            S_ISSUE: begin
                lat_cnt_d = LAT_INIT;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    // Only the owner's data register is touched
                    if (owner_q == OWNER_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory fields are presented only during ISSUE and are zero otherwise
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_be    = mem_en ? be_q : '0;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign if_ack    = (state_q == S_DONE) && (owner_q == OWNER_IF);
    assign dm_ack    = (state_q == S_DONE) && (owner_q == OWNER_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
